// File: rtl/fli_ctrl_pkg.sv
// rtl/fli_ctrl_pkg.sv - shared types, format codes and format legality for the FLI writeback controller
package fli_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WB     = 2'd2
    } fli_state_t;

    localparam logic [1:0] FMT_S = 2'b00;
    localparam logic [1:0] FMT_D = 2'b01;
    localparam logic [1:0] FMT_H = 2'b10;
    localparam logic [1:0] FMT_Q = 2'b11;

    // Single is always legal; the others follow the configured FPU extensions.
    function automatic logic fmt_legal(input logic [1:0] fmt, input logic zfh,
                                       input logic d, input logic q);
        case (fmt)
            FMT_S:   return 1'b1;
            FMT_D:   return d;
            FMT_H:   return zfh;
            default: return q;
        endcase
    endfunction

endpackage

// File: rtl/fli.sv
// rtl/fli.sv - FLI constant table: 32 immediates encoded per format and NaN-boxed to FLEN
module fli #(
    parameter int FLEN = 64
) (
    input  logic [4:0]      rs1_i,
    input  logic [1:0]      fmt_i,
    output logic [FLEN-1:0] data_o
);
    import fli_ctrl_pkg::*;

    typedef enum logic [1:0] {K_NORM, K_MIN, K_INF, K_NAN} kind_t;

    kind_t              kind;
    logic               sign;
    logic signed [5:0]  ue;
    logic [1:0]         mant;

    // Each entry is (-1)^sign * 1.mant * 2^ue, or a format-dependent special value.
    always_comb begin
        sign = 1'b0;
        kind = K_NORM;
        ue   = 6'sd0;
        mant = 2'b00;
        case (rs1_i)
            5'd0:  sign = 1'b1;
            5'd1:  kind = K_MIN;
            5'd2:  ue = -6'sd16;
            5'd3:  ue = -6'sd15;
            5'd4:  ue = -6'sd8;
            5'd5:  ue = -6'sd7;
            5'd6:  ue = -6'sd4;
            5'd7:  ue = -6'sd3;
            5'd8:  ue = -6'sd2;
            5'd9:  begin ue = -6'sd2; mant = 2'b01; end
            5'd10: begin ue = -6'sd2; mant = 2'b10; end
            5'd11: begin ue = -6'sd2; mant = 2'b11; end
            5'd12: ue = -6'sd1;
            5'd13: begin ue = -6'sd1; mant = 2'b01; end
            5'd14: begin ue = -6'sd1; mant = 2'b10; end
            5'd15: begin ue = -6'sd1; mant = 2'b11; end
            5'd17: mant = 2'b01;
            5'd18: mant = 2'b10;
            5'd19: mant = 2'b11;
            5'd20: ue = 6'sd1;
            5'd21: begin ue = 6'sd1; mant = 2'b01; end
            5'd22: begin ue = 6'sd1; mant = 2'b10; end
            5'd23: ue = 6'sd2;
            5'd24: ue = 6'sd3;
            5'd25: ue = 6'sd4;
            5'd26: ue = 6'sd7;
            5'd27: ue = 6'sd8;
            5'd28: ue = 6'sd15;
            5'd29: ue = 6'sd16;
            5'd30: kind = K_INF;
            5'd31: kind = K_NAN;
            default: ;
        endcase
    end

    // Half cannot hold 2^-16/2^-15 as normals nor 2^16 at all: subnormal and overflow to inf.
    function automatic logic [FLEN-1:0] encode(input int eb, input int mb, input kind_t k,
                                               input logic s, input logic signed [5:0] e,
                                               input logic [1:0] m);
        logic [FLEN-1:0] exp_v;
        logic [FLEN-1:0] frac_v;
        int              maxexp;
        int              biased;
        maxexp = (1 << eb) - 1;
        biased = int'(e) + (maxexp >> 1);
        exp_v  = '0;
        frac_v = '0;
        case (k)
            K_MIN: exp_v = FLEN'(1);
            K_INF: exp_v = FLEN'(maxexp);
            K_NAN: begin
                exp_v  = FLEN'(maxexp);
                frac_v = FLEN'(1) << (mb - 1);
            end
            default: begin
                if (biased >= maxexp) begin
                    exp_v = FLEN'(maxexp);
                end else if (biased <= 0) begin
                    frac_v = FLEN'(1) << (mb - 1 + biased);
                end else begin
                    exp_v  = FLEN'(biased);
                    frac_v = FLEN'(m) << (mb - 2);
                end
            end
        endcase
        return ({FLEN{1'b1}} << (1 + eb + mb)) | (FLEN'(s) << (eb + mb))
             | (exp_v << mb) | frac_v;
    endfunction

    always_comb begin
        case (fmt_i)
            FMT_S:   data_o = encode(8, 23, kind, sign, ue, mant);
            FMT_D:   data_o = encode(11, 52, kind, sign, ue, mant);
            FMT_H:   data_o = encode(5, 10, kind, sign, ue, mant);
            default: data_o = encode(15, 112, kind, sign, ue, mant);
        endcase
    end

endmodule

// File: rtl/fli_wb_ctrl.sv
// rtl/fli_wb_ctrl.sv - FLI op sequencer: accept, table lookup, registered writeback with starvation escalation
module fli_wb_ctrl
    import fli_ctrl_pkg::*;
#(
    parameter int FLEN          = 64,
    parameter bit ZFH_SUPPORTED = 1'b0,
    parameter bit D_SUPPORTED   = 1'b1,
    parameter bit Q_SUPPORTED   = 1'b0,
    parameter int STALL_LIMIT   = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ReqValid,
    output logic            ReqReady,
    input  logic [4:0]      ReqRs1,
    input  logic [1:0]      ReqFmt,
    input  logic [4:0]      ReqRd,
    input  logic            Flush,
    output logic            WbValid,
    input  logic            WbGnt,
    output logic [4:0]      WbRd,
    output logic [FLEN-1:0] WbData,
    output logic            WbPrio,
    output logic            IllegalFmt,
    output logic            Busy,
    output logic [4:0]      BusyRd
);
    localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

    fli_state_t      state_q, state_d;
    logic [4:0]      rs1_q, rd_q, wb_rd_q;
    logic [1:0]      fmt_q;
    logic [FLEN-1:0] wb_data_q, lut_data;
    logic [7:0]      stall_q, stall_d;
    logic            illegal_q;
    logic            accept, legal, granted;

    fli #(.FLEN(FLEN)) u_fli (
        .rs1_i  (rs1_q),
        .fmt_i  (fmt_q),
        .data_o (lut_data)
    );

    assign legal   = fmt_legal(ReqFmt, ZFH_SUPPORTED, D_SUPPORTED, Q_SUPPORTED);
    assign accept  = ReqValid & ReqReady & ~Flush;
    assign granted = (state_q == WB) & WbGnt & ~Flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (Flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept && legal) state_d = LOOKUP;
                LOOKUP:  state_d = WB;
                WB:      if (WbGnt) state_d = (accept && legal) ? LOOKUP : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // A grant frees the write slot in the same cycle, so a new request may enter.
    always_comb begin
        ReqReady = (state_q == IDLE) || ((state_q == WB) && WbGnt);
        WbValid  = (state_q == WB);
        Busy     = (state_q != IDLE);
        BusyRd   = Busy ? rd_q : 5'd0;
        WbPrio   = WbValid && (stall_q == LIMIT);
    end

    always_comb begin
        stall_d = stall_q;
        if (Flush || granted) begin
            stall_d = 8'd0;
        end else if ((state_q == WB) && (stall_q < LIMIT)) begin
            stall_d = stall_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_q     <= '0;
            fmt_q     <= '0;
            rd_q      <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            stall_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                rs1_q <= ReqRs1;
                fmt_q <= ReqFmt;
                rd_q  <= ReqRd;
            end
            if (state_q == LOOKUP) begin
                wb_data_q <= lut_data;
                wb_rd_q   <= rd_q;
            end
            stall_q   <= stall_d;
            illegal_q <= accept & ~legal;
        end
    end

    assign WbData     = wb_data_q;
    assign WbRd       = wb_rd_q;
    assign IllegalFmt = illegal_q;

endmodule

// File: tb/tb_fli_wb_ctrl.sv
// tb/tb_fli_wb_ctrl.sv - self-checking bench for fli_wb_ctrl with a transaction-level reference model
module tb_fli_wb_ctrl;
    localparam int LIMIT = 15;

    logic        clk = 1'b0;
    logic        reset, ReqValid, ReqReady, Flush, WbValid, WbGnt, WbPrio, IllegalFmt, Busy;
    logic [4:0]  ReqRs1, ReqRd, WbRd, BusyRd;
    logic [1:0]  ReqFmt;
    logic [63:0] WbData;

    int checks = 0;
    int errors = 0;

    bit          m_pend, m_ill;
    int          m_age, m_den;
    logic [63:0] m_data;
    logic [4:0]  m_rd;
    bit          e_valid, e_ready, e_busy, e_prio;
    logic [4:0]  e_busyrd;

    fli_wb_ctrl dut (
        .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqRs1(ReqRs1),
        .ReqFmt(ReqFmt), .ReqRd(ReqRd), .Flush(Flush), .WbValid(WbValid), .WbGnt(WbGnt),
        .WbRd(WbRd), .WbData(WbData), .WbPrio(WbPrio), .IllegalFmt(IllegalFmt),
        .Busy(Busy), .BusyRd(BusyRd)
    );

    always #5 clk = ~clk;

    // Reference value of each immediate as a real number, then encoded via the host double format.
    function automatic logic [63:0] ref_data(input logic [4:0] i, input logic [1:0] f);
        real         v;
        logic [63:0] d;
        int          e;
        if (i == 5'd30) return (f == 2'b01) ? 64'h7FF0_0000_0000_0000 : 64'hFFFF_FFFF_7F80_0000;
        if (i == 5'd31) return (f == 2'b01) ? 64'h7FF8_0000_0000_0000 : 64'hFFFF_FFFF_7FC0_0000;
        case (int'(i))
            0:  v = -1.0;
            1:  v = (f == 2'b01) ? 2.0 ** (-1022.0) : 2.0 ** (-126.0);
            2:  v = 2.0 ** (-16.0);
            3:  v = 2.0 ** (-15.0);
            4:  v = 2.0 ** (-8.0);
            5:  v = 2.0 ** (-7.0);
            6:  v = 0.0625;
            7:  v = 0.125;
            8:  v = 0.25;
            9:  v = 0.3125;
            10: v = 0.375;
            11: v = 0.4375;
            12: v = 0.5;
            13: v = 0.625;
            14: v = 0.75;
            15: v = 0.875;
            16: v = 1.0;
            17: v = 1.25;
            18: v = 1.5;
            19: v = 1.75;
            20: v = 2.0;
            21: v = 2.5;
            22: v = 3.0;
            23: v = 4.0;
            24: v = 8.0;
            25: v = 16.0;
            26: v = 128.0;
            27: v = 256.0;
            28: v = 32768.0;
            default: v = 65536.0;
        endcase
        d = $realtobits(v);
        if (f == 2'b01) return d;
        e = int'(d[62:52]) - 1023 + 127;
        return {32'hFFFF_FFFF, d[63], e[7:0], d[51:29]};
    endfunction

    task automatic set_in(input bit v, input logic [4:0] r1, input logic [1:0] f,
                          input logic [4:0] rd, input bit g, input bit fl);
        ReqValid = v; ReqRs1 = r1; ReqFmt = f; ReqRd = rd; WbGnt = g; Flush = fl;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        tick; tick;
        reset = 1'b0;
        m_pend = 0; m_ill = 0; m_age = 0; m_den = 0;
    endtask

    task automatic model_eval;
        e_valid  = m_pend && (m_age >= 2);
        e_ready  = !m_pend || (e_valid && WbGnt);
        e_busy   = m_pend;
        e_busyrd = m_pend ? m_rd : 5'd0;
        e_prio   = e_valid && (m_den >= LIMIT);
    endtask

    task automatic model_update;
        if (Flush) begin
            m_pend = 0; m_den = 0; m_ill = 0;
        end else begin
            m_ill = 0;
            if (e_valid) begin
                if (WbGnt) begin m_pend = 0; m_den = 0; end
                else if (m_den < LIMIT) m_den++;
            end
            if (m_pend) m_age++;
            if (ReqValid && e_ready) begin
                if (ReqFmt[1] == 1'b0) begin
                    m_pend = 1; m_age = 1; m_rd = ReqRd; m_data = ref_data(ReqRs1, ReqFmt);
                end else begin
                    m_ill = 1;
                end
            end
        end
    endtask

    task automatic test_reset;
        do_reset;
        set_in(0, 0, 0, 0, 0, 0);
        checks++;
        if ({WbValid, ReqReady, Busy, BusyRd, WbPrio, IllegalFmt, WbRd} !== {1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0}) begin
            errors++; $display("FAIL reset_outputs: got V=%b R=%b B=%b BRd=%0d P=%b I=%b Rd=%0d, want V=0 R=1 B=0 BRd=0 P=0 I=0 Rd=0",
                               WbValid, ReqReady, Busy, BusyRd, WbPrio, IllegalFmt, WbRd);
        end
        checks++;
        if (WbData !== 64'd0) begin errors++; $display("FAIL reset_data: got %h want 0", WbData); end
        tick;
    endtask

    task automatic test_single;
        set_in(1, 16, 2'b00, 5, 1, 0);
        checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL s_ready: got %b want 1", ReqReady); end
        tick;
        set_in(0, 0, 0, 0, 1, 0);
        checks++;
        if ({WbValid, Busy, BusyRd, ReqReady} !== {1'b0, 1'b1, 5'd5, 1'b0}) begin
            errors++; $display("FAIL s_lookup: got V=%b B=%b BRd=%0d R=%b want V=0 B=1 BRd=5 R=0", WbValid, Busy, BusyRd, ReqReady);
        end
        tick;
        checks++;
        if ({WbValid, WbRd, WbData} !== {1'b1, 5'd5, 64'hFFFF_FFFF_3F80_0000}) begin
            errors++; $display("FAIL s_wb: got V=%b Rd=%0d D=%h want V=1 Rd=5 D=ffffffff3f800000", WbValid, WbRd, WbData);
        end
        tick;
        checks++; if (WbValid !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL s_done: got V=%b B=%b want 0 0", WbValid, Busy); end
    endtask

    task automatic test_stall;
        set_in(1, 0, 2'b01, 7, 0, 0); tick;
        set_in(0, 0, 0, 0, 0, 0); tick;
        for (int k = 1; k <= 20; k++) begin
            checks++;
            if ({WbValid, WbRd, WbData, WbPrio} !== {1'b1, 5'd7, 64'hBFF0_0000_0000_0000, (k > LIMIT)}) begin
                errors++; $display("FAIL stall_%0d: got V=%b Rd=%0d D=%h P=%b want V=1 Rd=7 D=bff0000000000000 P=%b",
                                   k, WbValid, WbRd, WbData, WbPrio, (k > LIMIT));
            end
            tick;
        end
        set_in(0, 0, 0, 0, 1, 0); tick;
        set_in(0, 0, 0, 0, 0, 0);
        checks++;
        if ({WbPrio, WbValid, Busy, ReqReady} !== 4'b0001) begin
            errors++; $display("FAIL stall_grant: got P=%b V=%b B=%b R=%b want 0 0 0 1", WbPrio, WbValid, Busy, ReqReady);
        end
    endtask

    task automatic test_illegal;
        set_in(1, 3, 2'b10, 9, 0, 0);
        checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL ill_ready: got %b want 1", ReqReady); end
        tick;
        set_in(0, 0, 0, 0, 0, 0);
        checks++;
        if ({IllegalFmt, WbValid, ReqReady, Busy} !== 4'b1010) begin
            errors++; $display("FAIL ill_pulse: got I=%b V=%b R=%b B=%b want 1 0 1 0", IllegalFmt, WbValid, ReqReady, Busy);
        end
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++;
            if ({IllegalFmt, WbValid, ReqReady} !== 3'b001) begin
                errors++; $display("FAIL ill_after_%0d: got I=%b V=%b R=%b want 0 0 1", k, IllegalFmt, WbValid, ReqReady);
            end
        end
    endtask

    task automatic test_flush_wb;
        set_in(1, 16, 2'b01, 3, 0, 0); tick;
        set_in(0, 0, 0, 0, 0, 0); tick;
        for (int k = 0; k < 16; k++) tick;
        checks++; if (WbPrio !== 1'b1) begin errors++; $display("FAIL flush_prio_pre: got %b want 1", WbPrio); end
        set_in(0, 0, 0, 0, 1, 1); tick;
        set_in(0, 0, 0, 0, 0, 0);
        checks++;
        if ({WbValid, Busy, WbPrio, ReqReady} !== 4'b0001) begin
            errors++; $display("FAIL flush_wb: got V=%b B=%b P=%b R=%b want 0 0 0 1", WbValid, Busy, WbPrio, ReqReady);
        end
        set_in(1, 17, 2'b00, 4, 0, 0); tick;
        set_in(0, 0, 0, 0, 0, 0); tick;
        checks++;
        if ({WbValid, WbPrio} !== 2'b10) begin
            errors++; $display("FAIL flush_cnt_clr: got V=%b P=%b want V=1 P=0", WbValid, WbPrio);
        end
        set_in(0, 0, 0, 0, 1, 0); tick;
    endtask

    task automatic test_flush_idle;
        set_in(1, 16, 2'b00, 4, 1, 1); tick;
        set_in(0, 0, 0, 0, 1, 0);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy: got %b want 0", Busy); end
        tick;
        checks++; if (WbValid !== 1'b0) begin errors++; $display("FAIL flush_idle_wb: got %b want 0", WbValid); end
    endtask

    task automatic test_back_to_back;
        set_in(1, 30, 2'b00, 1, 1, 0); tick;
        set_in(0, 0, 0, 0, 1, 0);
        checks++; if (WbValid !== 1'b0) begin errors++; $display("FAIL b2b_c1: got V=%b want 0", WbValid); end
        tick;
        set_in(1, 31, 2'b00, 2, 1, 0);
        checks++;
        if ({WbValid, WbRd, WbData, ReqReady} !== {1'b1, 5'd1, 64'hFFFF_FFFF_7F80_0000, 1'b1}) begin
            errors++; $display("FAIL b2b_first: got V=%b Rd=%0d D=%h R=%b want 1 1 ffffffff7f800000 1", WbValid, WbRd, WbData, ReqReady);
        end
        tick;
        set_in(0, 0, 0, 0, 1, 0);
        checks++;
        if ({WbValid, Busy, BusyRd} !== {1'b0, 1'b1, 5'd2}) begin
            errors++; $display("FAIL b2b_gap: got V=%b B=%b BRd=%0d want 0 1 2", WbValid, Busy, BusyRd);
        end
        tick;
        checks++;
        if ({WbValid, WbRd, WbData} !== {1'b1, 5'd2, 64'hFFFF_FFFF_7FC0_0000}) begin
            errors++; $display("FAIL b2b_second: got V=%b Rd=%0d D=%h want 1 2 ffffffff7fc00000", WbValid, WbRd, WbData);
        end
        tick;
        checks++; if (WbValid !== 1'b0) begin errors++; $display("FAIL b2b_end: got V=%b want 0", WbValid); end
    endtask

    task automatic test_reset_lookup;
        set_in(1, 20, 2'b00, 9, 1, 0); tick;
        reset = 1'b1;
        set_in(0, 0, 0, 0, 1, 0);
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL rst_lk_pre: got B=%b want 1", Busy); end
        tick;
        reset = 1'b0;
        #1;
        checks++;
        if ({WbValid, Busy, BusyRd, ReqReady, WbData} !== {1'b0, 1'b0, 5'd0, 1'b1, 64'd0}) begin
            errors++; $display("FAIL rst_lk: got V=%b B=%b BRd=%0d R=%b D=%h want 0 0 0 1 0", WbValid, Busy, BusyRd, ReqReady, WbData);
        end
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++; if (WbValid !== 1'b0) begin errors++; $display("FAIL rst_lk_stale_%0d: got V=%b want 0", k, WbValid); end
        end
    endtask

    task automatic test_random;
        do_reset;
        for (int c = 0; c < 1500; c++) begin
            set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                   5'($urandom_range(0, 31)), $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
            model_eval;
            checks++;
            if ({WbValid, ReqReady, Busy, BusyRd, WbPrio, IllegalFmt} !== {e_valid, e_ready, e_busy, e_busyrd, e_prio, m_ill}) begin
                errors++; $display("FAIL rand_ctl_%0d: got V=%b R=%b B=%b BRd=%0d P=%b I=%b want V=%b R=%b B=%b BRd=%0d P=%b I=%b",
                                   c, WbValid, ReqReady, Busy, BusyRd, WbPrio, IllegalFmt,
                                   e_valid, e_ready, e_busy, e_busyrd, e_prio, m_ill);
            end
            if (e_valid) begin
                checks++;
                if ({WbRd, WbData} !== {m_rd, m_data}) begin
                    errors++; $display("FAIL rand_data_%0d: got Rd=%0d D=%h want Rd=%0d D=%h", c, WbRd, WbData, m_rd, m_data);
                end
            end
            model_update;
            tick;
        end
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        test_reset;
        test_single;
        test_stall;
        test_illegal;
        test_flush_wb;
        test_flush_idle;
        test_back_to_back;
        test_reset_lookup;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
